astropix_spi_protocol_av2: RTL and testbench

Second-generation per-layer AstroPix frame decoder. It sits between the SPI readout byte stream and the layer FIFO/switch and takes raw chip bytes over AXI-Stream. It drives readout on interrupt, recognises frames, and emits self-describing packets: length, layer ID, header, payload, then a timestamp of configurable size. Over the previous generation it adds a parametrised timestamp width, a configurable length field, full-throughput forwarding, optional dropping of wrong-length frames, and a per-byte receive timeout with padding.

---
 rtl/astropix_protocol_pkg.sv | 22 ++
 rtl/astropix_readout_trigger.sv | 35 +++
 rtl/astropix_spi_protocol_av2.sv | 235 +++++++++++++++++++++++
 tb/tb_astropix_spi_protocol_av2.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/astropix_protocol_pkg.sv
// rtl/astropix_protocol_pkg.sv - shared types and helpers for the AstroPix layer frame decoder
package astropix_protocol_pkg;

    typedef enum logic [2:0] {
        WAIT_FRAME,
        HDR_LEN,
        HDR_ID,
        HDR_FRAME,
        PAYLOAD,
        TSTAMP,
        DISCARD
    } state_t;

    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h3D;
    localparam logic [7:0] DEFAULT_PAD_BYTE  = 8'hFF;

    // Length field counts ID + header + payload + timestamp, not itself.
    function automatic logic [7:0] packet_length(input logic [7:0] len, input int ts_bytes);
        return len + ts_bytes[7:0] + 8'd2;
    endfunction

endpackage

// File: rtl/astropix_readout_trigger.sv
// rtl/astropix_readout_trigger.sv - interrupt driven readout request with idle-byte tail
module astropix_readout_trigger (
    input  logic       clk,
    input  logic       res,
    input  logic       layer_reset,
    input  logic       interruptn,
    input  logic       disable_autoread,
    input  logic [7:0] nodata_continue,
    input  logic       in_wait_frame,
    input  logic       idle_accept,
    output logic       readout_active
);

    logic [7:0] nodata_continue_counter;

    // A held interrupt reloads the tail counter, so it wins over an idle decrement.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            nodata_continue_counter <= 8'd0;
            readout_active          <= 1'b0;
        end else if (layer_reset) begin
            nodata_continue_counter <= 8'd0;
            readout_active          <= 1'b0;
        end else if (!interruptn && !disable_autoread) begin
            nodata_continue_counter <= nodata_continue;
            readout_active          <= 1'b1;
        end else if (in_wait_frame) begin
            if (nodata_continue_counter == 8'd0)
                readout_active <= 1'b0;
            else if (idle_accept)
                nodata_continue_counter <= nodata_continue_counter - 8'd1;
        end
    end

endmodule

// File: rtl/astropix_spi_protocol_av2.sv
// rtl/astropix_spi_protocol_av2.sv - per-layer AstroPix frame decoder and packetiser
module astropix_spi_protocol_av2
    import astropix_protocol_pkg::*;
#(
    parameter logic [7:0] LAYER_ID        = 8'h00,
    parameter logic [7:0] IDLE_BYTE       = DEFAULT_IDLE_BYTE,
    parameter int         LEN_BITS        = 3,
    parameter int         EXPECTED_LENGTH = 4,
    parameter int         TS_BYTES        = 4,
    parameter logic [7:0] PAD_BYTE        = DEFAULT_PAD_BYTE
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  interruptn,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [7:0]            m_axis_tdest,
    output logic                  readout_active,
    output logic                  stat_frame_detected,
    output logic                  stat_idle_detected,
    output logic                  stat_wronglength_detected,
    output logic                  stat_timeout_detected,
    output logic                  stat_frame_dropped,
    output logic                  status_frame_decoding,
    input  logic                  cfg_disable_autoread,
    input  logic [8*TS_BYTES-1:0] cfg_frame_tag_counter,
    input  logic [7:0]            cfg_nodata_continue,
    input  logic                  cfg_drop_wronglength,
    input  logic [15:0]           cfg_byte_timeout,
    input  logic                  cfg_layer_reset
);

    localparam logic [LEN_BITS-1:0] EXP_LEN = LEN_BITS'(EXPECTED_LENGTH);
    localparam logic [LEN_BITS-1:0] ONE_LEFT = LEN_BITS'(1);
    localparam logic [2:0]          TS_LAST = 3'(TS_BYTES - 1);

    state_t                state, state_n;
    logic [LEN_BITS-1:0]   len_q, remain_q;
    logic [7:0]            hdr_q;
    logic [8*TS_BYTES-1:0] ts_q;
    logic [2:0]            ts_idx_q;
    logic [15:0]           tmo_q;
    logic                  pad_q;

    logic                  can_load, load, load_last;
    logic [7:0]            load_data;
    logic                  hdr_take, idle_take, wrong_len, drop, count_tick, tmo_fire, waiting;
    logic [LEN_BITS-1:0]   hdr_len;
    logic                  tmo_expire;

    assign can_load   = !m_axis_tvalid || m_axis_tready;
    assign hdr_len    = s_axis_tdata[LEN_BITS-1:0];
    assign tmo_expire = (cfg_byte_timeout != 16'd0) && (tmo_q == cfg_byte_timeout - 16'd1);
    assign m_axis_tdest          = 8'h00;
    assign status_frame_decoding = (state != WAIT_FRAME);

    always_ff @(posedge clk or posedge res) begin
        if (res)
            state <= WAIT_FRAME;
        else if (cfg_layer_reset)
            state <= WAIT_FRAME;
        else
            state <= state_n;
    end

    // The length byte is loaded straight from WAIT_FRAME when the output slot is free;
    // HDR_LEN only holds it while the previous packet's last beat is still stalled.
    always_comb begin
        state_n       = state;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        load_data     = 8'h00;
        load_last     = 1'b0;
        hdr_take      = 1'b0;
        idle_take     = 1'b0;
        wrong_len     = 1'b0;
        drop          = 1'b0;
        count_tick    = 1'b0;
        tmo_fire      = 1'b0;
        waiting       = 1'b0;
        case (state)
            WAIT_FRAME: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (s_axis_tdata == IDLE_BYTE) begin
                        idle_take = 1'b1;
                    end else begin
                        hdr_take  = 1'b1;
                        wrong_len = (hdr_len != EXP_LEN);
                        if (wrong_len && cfg_drop_wronglength) begin
                            drop    = 1'b1;
                            state_n = (hdr_len == '0) ? WAIT_FRAME : DISCARD;
                        end else if (can_load) begin
                            load      = 1'b1;
                            load_data = packet_length(8'(hdr_len), TS_BYTES);
                            state_n   = HDR_ID;
                        end else begin
                            state_n = HDR_LEN;
                        end
                    end
                end
            end
            HDR_LEN: if (can_load) begin
                load      = 1'b1;
                load_data = packet_length(8'(len_q), TS_BYTES);
                state_n   = HDR_ID;
            end
            HDR_ID: if (can_load) begin
                load      = 1'b1;
                load_data = LAYER_ID;
                state_n   = HDR_FRAME;
            end
            HDR_FRAME: if (can_load) begin
                load      = 1'b1;
                load_data = hdr_q;
                state_n   = (len_q != '0) ? PAYLOAD : TSTAMP;
            end
            PAYLOAD: begin
                if (pad_q) begin
                    if (can_load) begin
                        load       = 1'b1;
                        load_data  = PAD_BYTE;
                        count_tick = 1'b1;
                    end
                end else begin
                    s_axis_tready = can_load;
                    if (can_load && s_axis_tvalid) begin
                        load       = 1'b1;
                        load_data  = s_axis_tdata;
                        count_tick = 1'b1;
                    end else if (can_load) begin
                        waiting  = 1'b1;
                        tmo_fire = tmo_expire;
                    end
                end
                if (count_tick && remain_q == ONE_LEFT)
                    state_n = TSTAMP;
            end
            TSTAMP: if (can_load) begin
                load      = 1'b1;
                load_data = ts_q[{ts_idx_q, 3'b000} +: 8];
                load_last = (ts_idx_q == TS_LAST);
                if (load_last)
                    state_n = WAIT_FRAME;
            end
            DISCARD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    count_tick = 1'b1;
                    if (remain_q == ONE_LEFT)
                        state_n = WAIT_FRAME;
                end else begin
                    waiting  = 1'b1;
                    tmo_fire = tmo_expire;
                    if (tmo_expire)
                        state_n = WAIT_FRAME;
                end
            end
            default: state_n = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            len_q <= '0; remain_q <= '0; hdr_q <= 8'h00; ts_q <= '0;
            ts_idx_q <= 3'd0; tmo_q <= 16'd0; pad_q <= 1'b0;
            m_axis_tdata <= 8'h00; m_axis_tvalid <= 1'b0; m_axis_tlast <= 1'b0;
            stat_frame_detected <= 1'b0; stat_idle_detected <= 1'b0;
            stat_wronglength_detected <= 1'b0; stat_timeout_detected <= 1'b0;
            stat_frame_dropped <= 1'b0;
        end else if (cfg_layer_reset) begin
            len_q <= '0; remain_q <= '0; hdr_q <= 8'h00; ts_q <= '0;
            ts_idx_q <= 3'd0; tmo_q <= 16'd0; pad_q <= 1'b0;
            m_axis_tdata <= 8'h00; m_axis_tvalid <= 1'b0; m_axis_tlast <= 1'b0;
            stat_frame_detected <= 1'b0; stat_idle_detected <= 1'b0;
            stat_wronglength_detected <= 1'b0; stat_timeout_detected <= 1'b0;
            stat_frame_dropped <= 1'b0;
        end else begin
            if (hdr_take) begin
                len_q    <= hdr_len;
                remain_q <= hdr_len;
                hdr_q    <= s_axis_tdata;
                ts_q     <= cfg_frame_tag_counter;
                ts_idx_q <= 3'd0;
            end else if (count_tick) begin
                remain_q <= remain_q - ONE_LEFT;
            end
            if (load && state == TSTAMP)
                ts_idx_q <= ts_idx_q + 3'd1;

            // Timeout only counts cycles spent starved by the upstream, not downstream stalls.
            if (waiting && !tmo_fire)
                tmo_q <= tmo_q + 16'd1;
            else if (!waiting && (state == PAYLOAD || state == DISCARD) && !count_tick)
                tmo_q <= tmo_q;
            else
                tmo_q <= 16'd0;

            pad_q <= (state == PAYLOAD) && (state_n == PAYLOAD) && (pad_q || tmo_fire);

            if (load) begin
                m_axis_tdata  <= load_data;
                m_axis_tlast  <= load_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end

            stat_frame_detected       <= hdr_take;
            stat_idle_detected        <= idle_take;
            stat_wronglength_detected <= wrong_len;
            stat_timeout_detected     <= tmo_fire;
            stat_frame_dropped        <= drop;
        end
    end

    astropix_readout_trigger u_trigger (
        .clk              (clk),
        .res              (res),
        .layer_reset      (cfg_layer_reset),
        .interruptn       (interruptn),
        .disable_autoread (cfg_disable_autoread),
        .nodata_continue  (cfg_nodata_continue),
        .in_wait_frame    (state == WAIT_FRAME),
        .idle_accept      (idle_take),
        .readout_active   (readout_active)
    );

endmodule

// File: tb/tb_astropix_spi_protocol_av2.sv
// tb/tb_astropix_spi_protocol_av2.sv - scoreboard bench for astropix_spi_protocol_av2
module tb_astropix_spi_protocol_av2;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        interruptn = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [7:0]  m_tdest;
    logic        readout_active;
    logic        st_frame, st_idle, st_wrong, st_tmo, st_drop, st_decoding;
    logic        cfg_disable_autoread = 1'b0;
    logic [31:0] cfg_tag = 32'h0;
    logic [7:0]  cfg_nodata = 8'd0;
    logic        cfg_drop = 1'b0;
    logic [15:0] cfg_tmo = 16'd0;
    logic        cfg_layer_reset = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_frame = 0, n_idle = 0, n_wrong = 0, n_tmo = 0, n_drop = 0;
    int pkt_start = 0, pkt_beats = 0;
    bit pkt_first = 1'b1;
    bit bp = 1'b0;
    bit stall_prev = 1'b0;
    logic [8:0] prev_beat = 9'h0;
    logic [8:0] exp_q[$];

    astropix_spi_protocol_av2 dut (
        .clk                       (clk),
        .res                       (res),
        .interruptn                (interruptn),
        .s_axis_tdata              (s_tdata),
        .s_axis_tvalid             (s_tvalid),
        .s_axis_tready             (s_tready),
        .m_axis_tdata              (m_tdata),
        .m_axis_tvalid             (m_tvalid),
        .m_axis_tready             (m_tready),
        .m_axis_tlast              (m_tlast),
        .m_axis_tdest              (m_tdest),
        .readout_active            (readout_active),
        .stat_frame_detected       (st_frame),
        .stat_idle_detected        (st_idle),
        .stat_wronglength_detected (st_wrong),
        .stat_timeout_detected     (st_tmo),
        .stat_frame_dropped        (st_drop),
        .status_frame_decoding     (st_decoding),
        .cfg_disable_autoread      (cfg_disable_autoread),
        .cfg_frame_tag_counter     (cfg_tag),
        .cfg_nodata_continue       (cfg_nodata),
        .cfg_drop_wronglength      (cfg_drop),
        .cfg_byte_timeout          (cfg_tmo),
        .cfg_layer_reset           (cfg_layer_reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (st_frame) n_frame++;
        if (st_idle)  n_idle++;
        if (st_wrong) n_wrong++;
        if (st_tmo)   n_tmo++;
        if (st_drop)  n_drop++;
        if (res) begin
            stall_prev = 1'b0;
            pkt_first  = 1'b1;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_beat", 32'({m_tlast, m_tdata}), 32'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected no output", {m_tlast, m_tdata});
                end else begin
                    chk("beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
                end
                if (pkt_first) begin
                    pkt_start = cyc;
                    pkt_first = 1'b0;
                end
                if (m_tlast) begin
                    pkt_beats = cyc - pkt_start + 1;
                    pkt_first = 1'b1;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    task automatic send(input logic [7:0] b);
        bit hs;
        int guard = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) break;
            guard++;
            if (guard > 2000) begin
                chk("send_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        idle_cycles(3);
    endtask

    // Pushes the expected packet (payload positions past nsent become FF) then drives the frame.
    task automatic run_frame(input logic [7:0] hdr, input int nsent, input logic [31:0] tag,
                             input logic [7:0] seed);
        int l;
        l = int'(hdr[2:0]);
        exp_q.push_back({1'b0, 8'(l + 6)});
        exp_q.push_back(9'h000);
        exp_q.push_back({1'b0, hdr});
        for (int k = 0; k < l; k++)
            exp_q.push_back({1'b0, (k < nsent) ? 8'(seed + 8'(k)) : 8'hFF});
        for (int t = 0; t < 4; t++)
            exp_q.push_back({t == 3, tag[8*t +: 8]});
        cfg_tag = tag;
        send(hdr);
        cfg_tag = ~tag;
        for (int k = 0; k < nsent; k++)
            send(8'(seed + 8'(k)));
    endtask

    initial begin
        int base;
        idle_cycles(3);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_readout", 32'(readout_active), 32'd0);
        chk("rst_decoding", 32'(st_decoding), 32'd0);
        res = 1'b0;
        idle_cycles(2);

        // Nominal frame, ready held high: 11 consecutive beats.
        exp_q.push_back(9'h00A); exp_q.push_back(9'h000); exp_q.push_back(9'h024);
        exp_q.push_back(9'h0AA); exp_q.push_back(9'h0BB); exp_q.push_back(9'h0CC);
        exp_q.push_back(9'h0DD); exp_q.push_back(9'h044); exp_q.push_back(9'h033);
        exp_q.push_back(9'h022); exp_q.push_back(9'h111);
        cfg_tag = 32'h11223344;
        send(8'h24);
        cfg_tag = 32'h0;
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        drain();
        chk("nominal_beats", 32'(pkt_beats), 32'd11);
        chk("nominal_frames", 32'(n_frame), 32'd1);
        chk("nominal_wrong", 32'(n_wrong), 32'd0);
        chk("tdest", 32'(m_tdest), 32'd0);

        // Idle tail: readout stays up for three idle bytes after the interrupt releases.
        cfg_nodata = 8'd3;
        interruptn = 1'b0;
        idle_cycles(2);
        chk("int_readout", 32'(readout_active), 32'd1);
        interruptn = 1'b1;
        send(8'h3D);
        send(8'h3D);
        chk("tail_after2", 32'(readout_active), 32'd1);
        send(8'h3D);
        send(8'h3D);
        chk("tail_after4", 32'(readout_active), 32'd0);
        idle_cycles(2);
        chk("idle_pulses", 32'(n_idle), 32'd4);
        chk("idle_no_frame", 32'(n_frame), 32'd1);

        // Wrong length frame with drop enabled, then a good frame.
        cfg_drop = 1'b1;
        send(8'h22);
        send(8'h01);
        send(8'h02);
        idle_cycles(3);
        chk("drop_wrong", 32'(n_wrong), 32'd1);
        chk("drop_dropped", 32'(n_drop), 32'd1);
        chk("drop_decoding", 32'(st_decoding), 32'd0);
        run_frame(8'h24, 4, 32'hA1B2C3D4, 8'h50);
        drain();
        chk("after_drop_wrong", 32'(n_wrong), 32'd1);

        // Timeout after two payload bytes pads with FF and keeps the length.
        cfg_tmo = 16'd10;
        run_frame(8'h24, 2, 32'h0BADCAFE, 8'hAA);
        drain();
        chk("timeout_pulses", 32'(n_tmo), 32'd1);
        cfg_tmo = 16'd0;
        cfg_drop = 1'b0;

        // Backpressure over 100 frames with lengths 0..5.
        bp = 1'b1;
        base = n_frame;
        for (int i = 0; i < 100; i++)
            run_frame(8'h20 | 8'(i % 6), i % 6, 32'(i * 32'h01010101 + 32'h5), 8'(i * 7));
        drain();
        bp = 1'b0;
        idle_cycles(2);
        chk("bp_frames", 32'(n_frame - base), 32'd100);

        // Reset in the middle of the payload.
        run_frame(8'h24, 1, 32'h12345678, 8'h10);
        idle_cycles(1);
        res = 1'b1;
        exp_q.delete();
        #2;
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_tlast", 32'(m_tlast), 32'd0);
        chk("midrst_tdata", 32'(m_tdata), 32'd0);
        chk("midrst_decoding", 32'(st_decoding), 32'd0);
        idle_cycles(2);
        res = 1'b0;
        idle_cycles(2);
        run_frame(8'h24, 4, 32'hCAFEF00D, 8'h60);
        drain();
        chk("final_beats", 32'(pkt_beats), 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
